// File: rtl/tc_pl_spi_pkg.sv
// Shared types and constants for the PL SPI serial engine and its bench.
// chip_sel bit map matches the downstream fan-out stage; bits 5..7 are reserved.
package tc_pl_spi_pkg;

    localparam int SPI_SEL_W    = 8;
    localparam int SPI_MAX_BITS = 32;
    localparam int SPI_LEN_W    = $clog2(SPI_MAX_BITS);

    localparam int SEL_ADC0 = 0;
    localparam int SEL_FDA0 = 1;
    localparam int SEL_DAC0 = 2;
    localparam int SEL_DAC1 = 3;
    localparam int SEL_LPL0 = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SHIFT_H = 3'd2,
        ST_SHIFT_L = 3'd3,
        ST_GAP     = 3'd4
    } spi_state_e;

endpackage

// File: rtl/tc_pl_spi_tick.sv
// Half-period timer: reloads to HALF_DIV-1 on load and counts down to zero.
// tc is high in the last cycle of each HALF_DIV-cycle window.
module tc_pl_spi_tick #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);

    localparam int CW = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/tc_pl_spi_master.sv
// Mode-0, MSB-first SPI master feeding the PL chip-select fan-out stage.
// One command per frame; read word returned with a single-cycle rsp_valid.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | CSN high, waiting for cmd_valid
// SETUP    | CSN low, SCLK low, first bit already on MOSI
// SHIFT_H  | SCLK high; MISO captured in the last cycle
// SHIFT_L  | SCLK low; next bit on MOSI; frame ends after bit 0
// GAP      | CSN high recovery time before the next command
module tc_pl_spi_master
    import tc_pl_spi_pkg::*;
#(
    parameter int SEL_W    = SPI_SEL_W,
    parameter int HALF_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SEL_W-1:0]        cmd_sel,
    input  logic [SPI_LEN_W-1:0]    cmd_len,
    input  logic [SPI_MAX_BITS-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [SPI_MAX_BITS-1:0] rsp_rdata,
    output logic                    busy,
    output logic [SEL_W-1:0]        chip_sel,
    output logic                    spi_CSN,
    output logic                    spi_SCLK,
    output logic                    spi_MOSI,
    input  logic                    spi_MISO
);

    spi_state_e                state_q, state_d;
    logic                      csn_q, csn_d;
    logic                      sclk_q, sclk_d;
    logic                      mosi_q, mosi_d;
    logic [SEL_W-1:0]          chip_sel_q, chip_sel_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [SPI_MAX_BITS-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                      busy_q, busy_d;
    logic [SPI_LEN_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SPI_MAX_BITS-1:0]   wdata_q, wdata_d;
    logic [SPI_MAX_BITS-1:0]   rx_q, rx_d;

    logic tick_load;
    logic tick_tc;

    // Timer is held loaded while idle so every state visit starts a fresh window.
    assign tick_load = (state_q == ST_IDLE) || tick_tc;

    tc_pl_spi_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (tick_load),
        .tc   (tick_tc)
    );

    assign cmd_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        csn_d       = csn_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        chip_sel_d  = chip_sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        bit_cnt_d   = bit_cnt_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d    = ST_SETUP;
                    csn_d      = 1'b0;
                    busy_d     = 1'b1;
                    chip_sel_d = cmd_sel;
                    wdata_d    = cmd_wdata;
                    bit_cnt_d  = cmd_len;
                    mosi_d     = cmd_wdata[cmd_len];
                    rx_d       = '0;
                end
            end
            ST_SETUP: begin
                if (tick_tc) begin
                    state_d = ST_SHIFT_H;
                    sclk_d  = 1'b1;
                end
            end
            ST_SHIFT_H: begin
                if (tick_tc) begin
                    state_d = ST_SHIFT_L;
                    sclk_d  = 1'b0;
                    rx_d    = {rx_q[SPI_MAX_BITS-2:0], spi_MISO};
                    mosi_d  = (bit_cnt_q != '0) ? wdata_q[bit_cnt_q - SPI_LEN_W'(1)] : 1'b0;
                end
            end
            ST_SHIFT_L: begin
                if (tick_tc) begin
                    if (bit_cnt_q == '0) begin
                        state_d     = ST_GAP;
                        csn_d       = 1'b1;
                        chip_sel_d  = '0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rx_q;
                    end else begin
                        state_d   = ST_SHIFT_H;
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q - SPI_LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick_tc) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            chip_sel_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            bit_cnt_q   <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
        end else begin
            state_q     <= state_d;
            csn_q       <= csn_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            chip_sel_q  <= chip_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            bit_cnt_q   <= bit_cnt_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
        end
    end

    assign spi_CSN   = csn_q;
    assign spi_SCLK  = sclk_q;
    assign spi_MOSI  = mosi_q;
    assign chip_sel  = chip_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tc_pl_spi_master.sv
// Self-checking bench for tc_pl_spi_master: scoreboard of expected frames,
// popped and compared when the DUT pulses rsp_valid.
module tb_tc_pl_spi_master;
    import tc_pl_spi_pkg::*;

    localparam int HD0 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_sel = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [7:0]  chip_sel;
    logic        spi_csn, spi_sclk, spi_mosi, spi_miso;

    logic        d1_valid = 1'b0;
    logic        d1_ready;
    logic [7:0]  d1_sel = '0;
    logic [4:0]  d1_len = '0;
    logic [31:0] d1_wdata = '0;
    logic        d1_rsp_valid;
    logic [31:0] d1_rsp_rdata;
    logic        d1_busy;
    logic [7:0]  d1_chip_sel;
    logic        d1_csn, d1_sclk, d1_mosi, d1_miso;

    // 0: loopback, 1: slave shift register, 2: tied high; fan-out gives 0 when nothing selected
    int          miso_mode = 0;
    logic [31:0] slave_word = '0;
    logic [4:0]  slave_bit = '0;

    assign spi_miso = (chip_sel == '0) ? 1'b0 :
                      (miso_mode == 0) ? spi_mosi :
                      (miso_mode == 1) ? slave_word[slave_bit] : 1'b1;
    assign d1_miso  = d1_mosi;

    tc_pl_spi_master #(.SEL_W(8), .HALF_DIV(HD0)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .chip_sel(chip_sel), .spi_CSN(spi_csn), .spi_SCLK(spi_sclk),
        .spi_MOSI(spi_mosi), .spi_MISO(spi_miso)
    );

    tc_pl_spi_master #(.SEL_W(8), .HALF_DIV(1)) dut_fast (
        .clk(clk), .rst(rst),
        .cmd_valid(d1_valid), .cmd_ready(d1_ready), .cmd_sel(d1_sel),
        .cmd_len(d1_len), .cmd_wdata(d1_wdata),
        .rsp_valid(d1_rsp_valid), .rsp_rdata(d1_rsp_rdata), .busy(d1_busy),
        .chip_sel(d1_chip_sel), .spi_CSN(d1_csn), .spi_SCLK(d1_sclk),
        .spi_MOSI(d1_mosi), .spi_MISO(d1_miso)
    );

    typedef struct {
        logic [7:0]  sel;
        logic [4:0]  len;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] len_mask(input logic [4:0] len);
        logic [32:0] m;
        m = (33'd1 << (6'(len) + 6'd1)) - 33'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [7:0] sel, input logic [4:0] len,
                                           input logic [31:0] wdata);
        if (sel == '0)      return 32'h0;
        if (miso_mode == 0) return wdata & len_mask(len);
        if (miso_mode == 1) return slave_word & len_mask(len);
        return len_mask(len);
    endfunction

    // Frame monitor for the HALF_DIV=4 instance
    int          lo_cnt = 0, hi_cnt = 0, edges = 0, last_gap = 0, rsp_count = 0;
    logic [31:0] mosi_cap = '0;
    logic [7:0]  sel_seen = '0;
    logic        prev_csn = 1'b1, prev_sclk = 1'b0, prev_rsp = 1'b0;
    logic        sel_bad = 1'b0, sclk_bad = 1'b0, gap_sel_bad = 1'b0, dbl_rsp = 1'b0;

    always @(negedge clk) begin
        if (spi_csn && spi_sclk) sclk_bad = 1'b1;
        if (prev_rsp && rsp_valid) dbl_rsp = 1'b1;
        if (prev_sclk && !spi_sclk) slave_bit = slave_bit - 5'd1;
        if (!spi_csn) begin
            if (prev_csn) begin
                last_gap = hi_cnt;
                hi_cnt   = 0;
                sel_seen = chip_sel;
            end
            lo_cnt++;
            if (chip_sel != sel_seen) sel_bad = 1'b1;
            if (spi_sclk && !prev_sclk) begin
                edges++;
                mosi_cap = {mosi_cap[30:0], spi_mosi};
            end
        end else begin
            hi_cnt++;
            if (chip_sel != '0) gap_sel_bad = 1'b1;
        end
        if (rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("sclk_edges", edges, 32'(mon_e.len) + 32'd1);
                chk("csn_low_cycles", lo_cnt, HD0 * (1 + 2 * (int'(mon_e.len) + 1)));
                chk("chip_sel_frame", {24'd0, sel_seen}, {24'd0, mon_e.sel});
                chk("chip_sel_stable", {31'd0, sel_bad}, 32'd0);
                chk("mosi_seq", mosi_cap & len_mask(mon_e.len), mon_e.wdata & len_mask(mon_e.len));
                chk("csn_at_rsp", {31'd0, spi_csn}, 32'd1);
            end
        end
        if (spi_csn && !prev_csn) begin
            lo_cnt   = 0;
            edges    = 0;
            mosi_cap = '0;
            sel_bad  = 1'b0;
        end
        prev_csn  = spi_csn;
        prev_sclk = spi_sclk;
        prev_rsp  = rsp_valid;
    end

    // Caller is just past a negedge; returns just past the accepting edge with cmd_valid still high.
    task automatic send(input logic [7:0] sel, input logic [4:0] len, input logic [31:0] wdata);
        exp_t e;
        int   n;
        cmd_sel   = sel;
        cmd_len   = len;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
        e.sel   = sel;
        e.len   = len;
        e.wdata = wdata;
        e.rdata = exp_rd(sel, len, wdata);
        exp_q.push_back(e);
        slave_bit = len;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_time", {31'd0, (n < 3000)}, 32'd1);
    endtask

    int   rc, rises, lo, first_rise, period, rsp_n;
    logic prev_s;
    logic [31:0] rd;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_csn",      {31'd0, spi_csn},   32'd1);
        chk("rst_sclk",     {31'd0, spi_sclk},  32'd0);
        chk("rst_mosi",     {31'd0, spi_mosi},  32'd0);
        chk("rst_chip_sel", {24'd0, chip_sel},  32'd0);
        chk("rst_rsp",      {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata",    rsp_rdata,          32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_ready",    {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 16-bit loopback on ADC0
        miso_mode = 0;
        send(8'(1 << SEL_ADC0), 5'd15, 32'h0000_A5C3);
        cmd_valid = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("rdata_hold", rsp_rdata, 32'h0000_A5C3);

        // 32-bit with slave returning DEADBEEF; a command during the frame must be ignored
        miso_mode  = 1;
        slave_word = 32'hDEAD_BEEF;
        send(8'(1 << SEL_FDA0), 5'd31, 32'h1234_5678);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_in_frame",  {31'd0, busy},      32'd1);
        chk("ready_in_frame", {31'd0, cmd_ready}, 32'd0);
        cmd_sel   = 8'h80;
        cmd_len   = 5'd3;
        cmd_wdata = 32'hF;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done();

        // single bit, MISO tied high
        miso_mode = 2;
        send(8'(1 << SEL_DAC0), 5'd0, 32'h1);
        cmd_valid = 1'b0;
        wait_done();

        // back-to-back with cmd_valid held high
        miso_mode = 0;
        send(8'(1 << SEL_DAC0), 5'd7, 32'h5A);
        send(8'(1 << SEL_LPL0), 5'd11, 32'hABC);
        cmd_valid = 1'b0;
        wait_done();
        chk("b2b_gap", last_gap, HD0 + 1);

        // no device selected, then multi-hot pass-through
        send(8'h00, 5'd7, 32'hFF);
        cmd_valid = 1'b0;
        wait_done();
        send(8'((1 << SEL_ADC0) | (1 << SEL_DAC0)), 5'd7, 32'h81);
        cmd_valid = 1'b0;
        wait_done();

        // reset during the 6th SHIFT_H
        send(8'(1 << SEL_DAC1), 5'd15, 32'hBEEF);
        cmd_valid = 1'b0;
        rises  = 0;
        prev_s = spi_sclk;
        for (int i = 0; i < 500 && rises < 6; i++) begin
            if (spi_sclk && !prev_s) rises++;
            prev_s = spi_sclk;
            if (rises < 6) @(negedge clk);
        end
        chk("abort_reached_6th", rises, 32'd6);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_csn",      {31'd0, spi_csn},   32'd1);
        chk("abort_sclk",     {31'd0, spi_sclk},  32'd0);
        chk("abort_chip_sel", {24'd0, chip_sel},  32'd0);
        chk("abort_busy",     {31'd0, busy},      32'd0);
        chk("abort_ready",    {31'd0, cmd_ready}, 32'd1);
        chk("abort_rsp",      {31'd0, rsp_valid}, 32'd0);
        exp_q.delete();
        rc = rsp_count;
        repeat (20) @(negedge clk);
        chk("abort_no_rsp", rsp_count, rc);
        send(8'(1 << SEL_DAC1), 5'd15, 32'h1357);
        cmd_valid = 1'b0;
        wait_done();

        // HALF_DIV=1 instance, 8-bit loopback
        chk("fast_ready", {31'd0, d1_ready}, 32'd1);
        d1_sel   = 8'h01;
        d1_len   = 5'd7;
        d1_wdata = 32'h3C;
        d1_valid = 1'b1;
        lo = 0; rises = 0; first_rise = 0; period = 0; rsp_n = 0; rd = '0; prev_s = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            d1_valid = 1'b0;
            if (!d1_csn) lo++;
            if (d1_sclk && !prev_s) begin
                rises++;
                if (rises == 1) first_rise = i;
                else if (rises == 2) period = i - first_rise;
            end
            prev_s = d1_sclk;
            if (d1_rsp_valid) begin
                rsp_n++;
                rd = d1_rsp_rdata;
            end
        end
        chk("fast_csn_low", lo,     32'd17);
        chk("fast_edges",   rises,  32'd8);
        chk("fast_period",  period, 32'd2);
        chk("fast_rsp_cnt", rsp_n,  32'd1);
        chk("fast_rdata",   rd,     32'h3C);

        chk("sclk_high_while_csn_high", {31'd0, sclk_bad},    32'd0);
        chk("chip_sel_zero_in_gap",     {31'd0, gap_sel_bad}, 32'd0);
        chk("rsp_single_pulse",         {31'd0, dbl_rsp},     32'd0);
        chk("scoreboard_empty",         exp_q.size(),         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
